// File: rtl/onehot_request_sequencer_if.sv
// Purpose : bundle of request, grant handshake and status signals for onehot_request_sequencer.
// Latency : none (wires only).
// Backpressure: valid/ready on the grant; ready is sampled only while valid=1.
// Ports   : req (8, level requests), onehot/valid (grant), ready (consumer accept),
//           pending (8, queued sources), drop_cnt (DROP_W, saturating lost-event count).
// Modports: slave = the sequencer, master = the agent driving req/ready.
interface onehot_request_sequencer_if #(
   parameter int DROP_W = 8
);
   logic [7:0]        req;
   logic [7:0]        onehot;
   logic              valid;
   logic              ready;
   logic [7:0]        pending;
   logic [DROP_W-1:0] drop_cnt;

   modport slave (
      input  req,
      input  ready,
      output onehot,
      output valid,
      output pending,
      output drop_cnt
   );

   modport master (
      output req,
      output ready,
      input  onehot,
      input  valid,
      input  pending,
      input  drop_cnt
   );
endinterface

// File: rtl/onehot_request_sequencer.sv
// Purpose : rising edges on 8 request lines become sticky pending bits, served round-robin as a one-hot grant.
// Latency : req rise -> pending after 1 edge, -> valid after 2 edges (+2 each with ONEHOT_SEQ_SYNC_EN).
// Backpressure: onehot held stable while ready=0; one grant per cycle with ready=1; events on a still-pending source are dropped and counted.
// Ports   : clk, rst_n (synchronous, active-low); bus (onehot_request_sequencer_if.slave):
//           req in, ready in, onehot/valid/pending/drop_cnt out (all registered).
// Build   : define ONEHOT_SEQ_SYNC_EN to put a two-flop synchronizer on every req bit.
module onehot_request_sequencer #(
   parameter int DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   onehot_request_sequencer_if.slave  bus
);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PRESENT = 1'b1;

   // Sum width wide enough for drop_cnt plus up to 8 drops without wrapping.
   localparam int              SW      = ((DROP_W > 4) ? DROP_W : 4) + 1;
   localparam logic [SW-1:0]   CNT_MAX = SW'({DROP_W{1'b1}});

   logic [0:0]        state;
   logic [7:0]        onehot_q;
   logic [7:0]        pending_q;
   logic [DROP_W-1:0] drop_q;
   logic [2:0]        ptr;
   logic [7:0]        req_q;
   logic [7:0]        req_s;

`ifdef ONEHOT_SEQ_SYNC_EN
   logic [7:0] sync1;
   logic [7:0] sync2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 8'h00;
         sync2 <= 8'h00;
      end else begin
         sync1 <= bus.req;
         sync2 <= sync1;
      end
   end

   assign req_s = sync2;
`else
   assign req_s = bus.req;
`endif

   // Round-robin search: first pending bit at or above ptr, wrapping modulo 8.
   logic       found;
   logic [2:0] gidx;
   logic [2:0] idx;

   always_comb begin
      found = 1'b0;
      gidx  = 3'd0;
      idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr + 3'(k);
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
   end

   logic [7:0] evt;
   logic [7:0] grant_oh;
   logic [7:0] clr;
   logic [7:0] drop;
   logic [7:0] pending_n;
   logic       load;

   assign evt      = req_s & ~req_q;
   assign grant_oh = 8'b1 << gidx;
   // A grant is loaded from IDLE whenever work exists, or back-to-back on an accepted transfer.
   assign load     = found && ((state == S_IDLE) || bus.ready);
   assign clr      = load ? grant_oh : 8'h00;
   // An event on the bit being granted this cycle re-arms it rather than being lost,
   // so it is not counted as a drop.
   assign drop     = evt & pending_q & ~clr;
   // Set wins over clear on the same bit.
   assign pending_n = (pending_q & ~clr) | evt;

   logic [3:0]    ndrop;
   logic [SW-1:0] drop_sum;
   logic [DROP_W-1:0] drop_n;

   always_comb begin
      ndrop = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ndrop = ndrop + {3'd0, drop[i]};
      end
      drop_sum = SW'(drop_q) + SW'(ndrop);
      drop_n   = (drop_sum > CNT_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         onehot_q  <= 8'h00;
         pending_q <= 8'h00;
         drop_q    <= '0;
         ptr       <= 3'd0;
         req_q     <= 8'h00;
      end else begin
         req_q     <= req_s;
         pending_q <= pending_n;
         drop_q    <= drop_n;
         if (load) begin
            state    <= S_PRESENT;
            onehot_q <= grant_oh;
            ptr      <= gidx + 3'd1;
         end else if ((state == S_PRESENT) && bus.ready) begin
            state    <= S_IDLE;
            onehot_q <= 8'h00;
         end
      end
   end

   assign bus.onehot   = onehot_q;
   assign bus.valid    = (state == S_PRESENT);
   assign bus.pending  = pending_q;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_onehot_request_sequencer.sv
// Purpose : self-checking bench for onehot_request_sequencer, scoreboarded grants plus per-scenario checks.
// Latency : expectations shift by EXT=2 cycles when ONEHOT_SEQ_SYNC_EN is defined.
// Backpressure: scenarios drive ready low/high explicitly; grants are popped from the scoreboard on valid&ready.
module tb_onehot_request_sequencer;

`ifdef ONEHOT_SEQ_SYNC_EN
   localparam int EXT = 2;
`else
   localparam int EXT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   onehot_request_sequencer_if #(.DROP_W(8)) bus();

   onehot_request_sequencer #(.DROP_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Scoreboard consumer and output-legality monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [7:0] exp;
      if (rst_n) begin
         if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got %b, expected no grant", bus.onehot);
            end else begin
               exp = sb.pop_front();
               if (bus.onehot !== exp) begin
                  n_fail++;
                  $display("FAIL sb_grant: got %b, expected %b", bus.onehot, exp);
               end
            end
         end
         n_checks++;
         if ((bus.valid === 1'b1) ? ($countones(bus.onehot) != 1) : (bus.onehot !== 8'h00)) begin
            n_fail++;
            $display("FAIL legal_onehot: got onehot=%b valid=%b, expected one-hot iff valid", bus.onehot, bus.valid);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Bounded wait for the scoreboard to empty and the output to go idle.
   task automatic drain(output int left);
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || bus.valid !== 1'b0) && cyc < 60) begin
         tick();
         cyc++;
      end
      left = sb.size() + ((bus.valid !== 1'b0) ? 1 : 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = 8'h00;
      bus.ready = 1'b0;
      ticks(2);
      n_checks++;
      if ({bus.onehot, bus.valid, bus.pending, bus.drop_cnt} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got onehot=%h valid=%b pending=%h drop=%0d, expected all 0",
                  bus.onehot, bus.valid, bus.pending, bus.drop_cnt);
      end
      n_checks++;
      if (dut.ptr !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ptr: got %0d, expected 0", dut.ptr);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bus.ready = 1'b1;
      bus.req = 8'h04;
      sb.push_back(8'h04);
      ticks(EXT + 1);
      n_checks++;
      if (bus.pending !== 8'h04 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_pending: got pending=%h valid=%b, expected 04/0", bus.pending, bus.valid);
      end
      tick();
      n_checks++;
      if (bus.onehot !== 8'h04 || bus.valid !== 1'b1 || bus.pending !== 8'h00) begin
         n_fail++;
         $display("FAIL single_grant: got onehot=%h valid=%b pending=%h, expected 04/1/00",
                  bus.onehot, bus.valid, bus.pending);
      end
      n_checks++;
      if (dut.ptr !== 3'd3) begin
         n_fail++;
         $display("FAIL single_ptr: got %0d, expected 3", dut.ptr);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.drop_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL single_idle: got valid=%b drop=%0d, expected 0/0", bus.valid, bus.drop_cnt);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_seq [3];
      exp_seq = '{8'h01, 8'h04, 8'h80};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.ready = 1'b1;
      bus.req = 8'h85;
      foreach (exp_seq[i]) sb.push_back(exp_seq[i]);
      ticks(EXT + 1);
      n_checks++;
      if (bus.pending !== 8'h85) begin
         n_fail++;
         $display("FAIL rr_pending: got %h, expected 85", bus.pending);
      end
      foreach (exp_seq[i]) begin
         tick();
         n_checks++;
         if (bus.onehot !== exp_seq[i] || bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got onehot=%h valid=%b, expected %h/1", i, bus.onehot, bus.valid, exp_seq[i]);
         end
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin
         n_fail++;
         $display("FAIL rr_idle: got valid=%b pending=%h, expected 0/00", bus.valid, bus.pending);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   task automatic test_backpressure();
      bus.ready = 1'b0;
      bus.req = 8'h02;
      sb.push_back(8'h02);
      sb.push_back(8'h10);
      tick();
      bus.req = 8'h12;
      ticks(EXT + 1);
      n_checks++;
      if (bus.onehot !== 8'h02 || bus.valid !== 1'b1 || bus.pending !== 8'h10) begin
         n_fail++;
         $display("FAIL bp_present: got onehot=%h valid=%b pending=%h, expected 02/1/10",
                  bus.onehot, bus.valid, bus.pending);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (bus.onehot !== 8'h02 || bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got onehot=%h valid=%b, expected 02/1", c, bus.onehot, bus.valid);
         end
      end
      bus.ready = 1'b1;
      tick();
      n_checks++;
      if (bus.onehot !== 8'h10 || bus.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_next: got onehot=%h valid=%b, expected 10/1", bus.onehot, bus.valid);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: got valid=%b, expected 0", bus.valid);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   task automatic test_drop();
      int left;
      bus.ready = 1'b0;
      bus.req = 8'h40;
      sb.push_back(8'h40);
      sb.push_back(8'h01);
      sb.push_back(8'h02);
      sb.push_back(8'h08);
      tick();
      bus.req = 8'h48;
      ticks(EXT + 1);
      n_checks++;
      if (bus.onehot !== 8'h40 || bus.pending !== 8'h08) begin
         n_fail++;
         $display("FAIL drop_setup: got onehot=%h pending=%h, expected 40/08", bus.onehot, bus.pending);
      end
      bus.req = 8'h40;
      tick();
      bus.req = 8'h48;
      ticks(EXT + 1);
      n_checks++;
      if (bus.drop_cnt !== 8'd1 || bus.pending !== 8'h08) begin
         n_fail++;
         $display("FAIL drop_one: got drop=%0d pending=%h, expected 1/08", bus.drop_cnt, bus.pending);
      end
      bus.req = 8'h4B;
      ticks(EXT + 1);
      bus.req = 8'h40;
      tick();
      bus.req = 8'h4B;
      ticks(EXT + 1);
      n_checks++;
      if (bus.drop_cnt !== 8'd4 || bus.pending !== 8'h0B) begin
         n_fail++;
         $display("FAIL drop_multi: got drop=%0d pending=%h, expected 4/0B", bus.drop_cnt, bus.pending);
      end
      for (int r = 0; r < 100; r++) begin
         bus.req = 8'h40;
         tick();
         bus.req = 8'h4B;
         tick();
      end
      ticks(EXT + 1);
      n_checks++;
      if (bus.drop_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL drop_saturate: got %0d, expected 255", bus.drop_cnt);
      end
      bus.ready = 1'b1;
      drain(left);
      n_checks++;
      if (left != 0) begin
         n_fail++;
         $display("FAIL drop_drain: got %0d outstanding, expected 0", left);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   task automatic test_set_beats_clear();
      bus.ready = 1'b0;
      bus.req = 8'h40;
      sb.push_back(8'h40);
      sb.push_back(8'h20);
      sb.push_back(8'h20);
      tick();
      bus.req = 8'h60;
      ticks(EXT + 1);
      n_checks++;
      if (bus.onehot !== 8'h40 || bus.pending !== 8'h20) begin
         n_fail++;
         $display("FAIL sbc_setup: got onehot=%h pending=%h, expected 40/20", bus.onehot, bus.pending);
      end
      bus.req = 8'h40;
      tick();
      bus.req = 8'h60;
      ticks(EXT);
      bus.ready = 1'b1;
      tick();
      n_checks++;
      if (bus.onehot !== 8'h20 || bus.valid !== 1'b1 || bus.pending !== 8'h20) begin
         n_fail++;
         $display("FAIL sbc_collide: got onehot=%h valid=%b pending=%h, expected 20/1/20",
                  bus.onehot, bus.valid, bus.pending);
      end
      tick();
      n_checks++;
      if (bus.onehot !== 8'h20 || bus.valid !== 1'b1 || bus.pending !== 8'h00) begin
         n_fail++;
         $display("FAIL sbc_regrant: got onehot=%h valid=%b pending=%h, expected 20/1/00",
                  bus.onehot, bus.valid, bus.pending);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sbc_idle: got valid=%b, expected 0", bus.valid);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   task automatic test_mid_reset();
      int left;
      bus.ready = 1'b0;
      bus.req = 8'h01;
      tick();
      bus.req = 8'hF1;
      ticks(EXT + 1);
      n_checks++;
      if (bus.onehot !== 8'h01 || bus.valid !== 1'b1 || bus.pending !== 8'hF0) begin
         n_fail++;
         $display("FAIL mrst_setup: got onehot=%h valid=%b pending=%h, expected 01/1/F0",
                  bus.onehot, bus.valid, bus.pending);
      end
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({bus.onehot, bus.valid, bus.pending, bus.drop_cnt} !== 25'd0 || dut.ptr !== 3'd0) begin
         n_fail++;
         $display("FAIL mrst_clear: got onehot=%h valid=%b pending=%h drop=%0d ptr=%0d, expected all 0",
                  bus.onehot, bus.valid, bus.pending, bus.drop_cnt, dut.ptr);
      end
      rst_n = 1'b1;
      bus.ready = 1'b1;
      sb.push_back(8'h01);
      sb.push_back(8'h10);
      sb.push_back(8'h20);
      sb.push_back(8'h40);
      sb.push_back(8'h80);
      ticks(EXT);
      n_checks++;
      if (bus.pending !== 8'h00) begin
         n_fail++;
         $display("FAIL mrst_early: got pending=%h, expected 00", bus.pending);
      end
      tick();
      n_checks++;
      if (bus.pending !== 8'hF1 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mrst_held_evt: got pending=%h valid=%b, expected F1/0", bus.pending, bus.valid);
      end
      tick();
      n_checks++;
      if (bus.onehot !== 8'h01 || bus.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mrst_first: got onehot=%h valid=%b, expected 01/1", bus.onehot, bus.valid);
      end
      drain(left);
      n_checks++;
      if (left != 0) begin
         n_fail++;
         $display("FAIL mrst_drain: got %0d outstanding, expected 0", left);
      end
      bus.req = 8'h00;
      ticks(EXT + 1);
   endtask

   initial begin
      bus.req = 8'h00;
      bus.ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_drop();
      test_set_beats_clear();
      test_mid_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
